// File: rtl/code_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : code_sequencer
// Description : Controller for the code storage block. Loads a program into
//               storage over a valid/ready stream, then sequences execution:
//               restarts the storage line counter, advances one line per
//               cycle, honours stall, and stops on a halt word or at the end
//               of the loaded program.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: BREAKPOINT_EN
//   When defined, adds bp_en/bp_line/resume and a PAUSE state that stops
//   execution on a chosen line until resume is pulsed.
// ----------------------------------------------------------------------------
// Ports
//   clk               in   1          clock, all state on rising edge
//   reset             in   1          asynchronous active-high reset
//   load_start        in   1          IDLE/DONE: begin program load at line 0
//   load_valid        in   1          load beat valid
//   load_ready        out  1          controller accepts the current beat
//   load_data         in   CODE_SIZE  code word of current beat
//   load_last         in   1          current beat is the final program word
//   run_start         in   1          IDLE/DONE: start execution (prog_len>0)
//   stall             in   1          RUN: hold the current line
//   abort             in   1          any state: return to IDLE
//   code              in   CODE_SIZE  storage: word at current line
//   code_index        in   32         storage: current line number
//   store_active      out  1          storage: advance line counter
//   store_reset       out  1          storage: clear line counter
//   store_is_write    out  1          storage: write enable
//   store_write_line  out  32         storage: write address
//   store_write_data  out  CODE_SIZE  storage: write data
//   prog_len          out  32         lines loaded by last completed load
//   exec_count        out  32         active cycles in current/last run
//   state             out  3          IDLE=0 LOAD=1 RUN=2 DONE=3 PAUSE=4
//   overflow          out  1          sticky: load filled storage w/o last
//   bp_en/bp_line/resume (BREAKPOINT_EN only) breakpoint control
// ============================================================================
module code_sequencer #(
  parameter int                   CODE_SIZE = 12,
  parameter int                   MAX_LINES = 100,
  parameter logic [CODE_SIZE-1:0] HALT_CODE = '1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [CODE_SIZE-1:0] load_data,
  input  logic                 load_last,
  input  logic                 run_start,
  input  logic                 stall,
  input  logic                 abort,
  input  logic [CODE_SIZE-1:0] code,
  input  logic [31:0]          code_index,
  output logic                 store_active,
  output logic                 store_reset,
  output logic                 store_is_write,
  output logic [31:0]          store_write_line,
  output logic [CODE_SIZE-1:0] store_write_data,
  output logic [31:0]          prog_len,
  output logic [31:0]          exec_count,
  output logic [2:0]           state,
  output logic                 overflow
`ifdef BREAKPOINT_EN
  ,
  input  logic                 bp_en,
  input  logic [31:0]          bp_line,
  input  logic                 resume
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  localparam logic [31:0] c_MAX_LINES = 32'(MAX_LINES);
  localparam logic [31:0] c_LAST_LINE = 32'(MAX_LINES - 1);

  state_t      state_q,      state_d;
  logic [31:0] load_count_q, load_count_d;
  logic [31:0] prog_len_q,   prog_len_d;
  logic [31:0] exec_count_q, exec_count_d;
  logic        overflow_q,   overflow_d;
`ifdef BREAKPOINT_EN
  // Set on resume so the breakpoint line itself does not re-trigger PAUSE.
  logic        bp_skip_q,    bp_skip_d;
`endif

  logic w_handshake;
  logic w_end_cond;

  assign load_ready  = (state_q == S_LOAD) && (load_count_q < c_MAX_LINES);
  assign w_handshake = load_valid && load_ready;
  assign w_end_cond  = (code == HALT_CODE) || (code_index >= prog_len_q);

  // --------------------------------------------------------------------------
  // State and counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      load_count_q <= '0;
      prog_len_q   <= '0;
      exec_count_q <= '0;
      overflow_q   <= 1'b0;
`ifdef BREAKPOINT_EN
      bp_skip_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      prog_len_q   <= prog_len_d;
      exec_count_q <= exec_count_d;
      overflow_q   <= overflow_d;
`ifdef BREAKPOINT_EN
      bp_skip_q    <= bp_skip_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and storage strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    load_count_d   = load_count_q;
    prog_len_d     = prog_len_q;
    exec_count_d   = exec_count_q;
    overflow_d     = overflow_q;
    store_active   = 1'b0;
    store_reset    = 1'b0;
    store_is_write = 1'b0;
`ifdef BREAKPOINT_EN
    bp_skip_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        // A new load takes precedence over starting execution.
        if (load_start) begin
          state_d      = S_LOAD;
          load_count_d = '0;
          overflow_d   = 1'b0;
        end else if (run_start && (prog_len_q != '0)) begin
          state_d      = S_RUN;
          exec_count_d = '0;
          store_reset  = 1'b1;
        end
      end

      S_LOAD: begin
        if (w_handshake) begin
          store_is_write = 1'b1;
          load_count_d   = load_count_q + 32'd1;
          if (load_last) begin
            prog_len_d = load_count_q + 32'd1;
            state_d    = S_IDLE;
          end else if (load_count_q == c_LAST_LINE) begin
            // Storage is full but the program has not ended: keep what fits.
            prog_len_d = c_MAX_LINES;
            overflow_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      S_RUN: begin
        // End condition beats stall and breakpoints; the halt line is
        // never advanced past.
        if (w_end_cond) begin
          state_d = S_DONE;
`ifdef BREAKPOINT_EN
        end else if (bp_en && (code_index == bp_line) && !bp_skip_q) begin
          state_d = S_PAUSE;
`endif
        end else begin
          store_active = !stall;
          if (!stall) begin
            exec_count_d = exec_count_q + 32'd1;
          end
        end
      end

`ifdef BREAKPOINT_EN
      S_PAUSE: begin
        if (resume) begin
          state_d   = S_RUN;
          bp_skip_d = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything: the current cycle's storage strobes and
    // counter updates are dropped and prog_len keeps its last value.
    if (abort) begin
      state_d        = S_IDLE;
      load_count_d   = load_count_q;
      prog_len_d     = prog_len_q;
      exec_count_d   = exec_count_q;
      overflow_d     = overflow_q;
      store_active   = 1'b0;
      store_reset    = 1'b0;
      store_is_write = 1'b0;
`ifdef BREAKPOINT_EN
      bp_skip_d      = 1'b0;
`endif
    end
  end

  assign store_write_line = load_count_q;
  assign store_write_data = load_data;
  assign prog_len         = prog_len_q;
  assign exec_count       = exec_count_q;
  assign state            = state_q;
  assign overflow         = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_code_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_sequencer
// Description : Self-checking bench for code_sequencer with a behavioural
//               code-storage model and a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_sequencer;

  localparam int             CS   = 12;
  localparam int             ML   = 100;
  localparam logic [CS-1:0]  HALT = '1;

  logic          clk;
  logic          reset;
  logic          load_start, load_valid, load_ready, load_last;
  logic [CS-1:0] load_data;
  logic          run_start, stall, abort;
  logic [CS-1:0] code;
  logic [31:0]   code_index;
  logic          store_active, store_reset, store_is_write;
  logic [31:0]   store_write_line;
  logic [CS-1:0] store_write_data;
  logic [31:0]   prog_len, exec_count;
  logic [2:0]    state;
  logic          overflow;
`ifdef BREAKPOINT_EN
  logic          bp_en, resume;
  logic [31:0]   bp_line;
`endif

  code_sequencer #(.CODE_SIZE(CS), .MAX_LINES(ML), .HALT_CODE(HALT)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last),
    .run_start(run_start), .stall(stall), .abort(abort),
    .code(code), .code_index(code_index),
    .store_active(store_active), .store_reset(store_reset),
    .store_is_write(store_is_write), .store_write_line(store_write_line),
    .store_write_data(store_write_data),
    .prog_len(prog_len), .exec_count(exec_count), .state(state),
    .overflow(overflow)
`ifdef BREAKPOINT_EN
    , .bp_en(bp_en), .bp_line(bp_line), .resume(resume)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Code storage model: write port plus line counter.
  logic [CS-1:0] mem [0:127];
  logic [31:0]   idx;
  assign code_index = idx;
  assign code       = (idx < 32'd128) ? mem[idx[6:0]] : '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else begin
      if (store_is_write && store_write_line < 32'd128)
        mem[store_write_line[6:0]] <= store_write_data;
      if (store_reset)       idx <= '0;
      else if (store_active) idx <= idx + 32'd1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Write scoreboard: expected writes are pushed when beats are driven.
  typedef struct { logic [31:0] line; logic [CS-1:0] data; } wr_t;
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (store_is_write) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: line %0d data %0h, no write expected",
                 store_write_line, store_write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_line", 64'(store_write_line), 64'(e.line));
        chk("write_data", 64'(store_write_data), 64'(e.data));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int n, input bit with_last, input int halt_pos);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = (i == halt_pos) ? HALT : CS'(i + 1);
      load_last  = with_last && (i == n - 1);
      if (i < ML) exp_q.push_back('{32'(i), load_data});
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_run(input string nm, input int exp_exec, input int exp_idx,
                        input int sline, input int sn);
    int cyc, act, st;
    cyc = 0; act = 0; st = 0;
    run_start = 1'b1;
    #1;
    chk({nm, "_store_reset"}, 64'(store_reset), 64'd1);
    tick();
    run_start = 1'b0;
    while (state != 3'd3 && cyc < 400) begin
      stall = (idx == 32'(sline)) && (st < sn);
      if (stall) st++;
      #1;
      if (store_active) act++;
      tick();
      cyc++;
    end
    stall = 1'b0;
    chk({nm, "_state_done"}, 64'(state), 64'd3);
    chk({nm, "_exec_count"}, 64'(exec_count), 64'(exp_exec));
    chk({nm, "_code_index"}, 64'(code_index), 64'(exp_idx));
    chk({nm, "_active_cycles"}, 64'(act), 64'(exp_exec));
    chk({nm, "_run_cycles"}, 64'(cyc), 64'(exp_exec + sn + 1));
  endtask

  typedef struct {
    string nm; int len; bit last; int halt; int sline; int sn;
    int eprog; int eexec; int eidx;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{"plain4",  4,  1'b1, -1, -1, 0, 4,  4,  4};
    tbl[1] = '{"halt2",   6,  1'b1,  2, -1, 0, 6,  2,  2};
    tbl[2] = '{"stall",   4,  1'b1, -1,  1, 3, 4,  4,  4};
    tbl[3] = '{"halt0",   1,  1'b1,  0, -1, 0, 1,  0,  0};
    tbl[4] = '{"full",    ML, 1'b1, -1, -1, 0, ML, ML, ML};

    reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    run_start = 0; stall = 0; abort = 0;
`ifdef BREAKPOINT_EN
    bp_en = 0; bp_line = '0; resume = 0;
`endif
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset values
    chk("rst_state",      64'(state),          64'd0);
    chk("rst_prog_len",   64'(prog_len),       64'd0);
    chk("rst_exec_count", 64'(exec_count),     64'd0);
    chk("rst_overflow",   64'(overflow),       64'd0);
    chk("rst_load_ready", 64'(load_ready),     64'd0);
    chk("rst_store",      64'({store_active, store_reset, store_is_write}), 64'd0);

    // run_start with empty program is ignored
    run_start = 1'b1;
    #1;
    chk("empty_run_store_reset", 64'(store_reset), 64'd0);
    tick();
    run_start = 1'b0;
    chk("empty_run_state", 64'(state), 64'd0);

    // Reset in the middle of a load, after three accepted beats
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = CS'(i + 1);
      exp_q.push_back('{32'(i), load_data});
      tick();
    end
    chk("midload_state", 64'(state), 64'd1);
    load_data = CS'(9);
    reset = 1'b1;
    #1;
    chk("midrst_state",      64'(state),          64'd0);
    chk("midrst_prog_len",   64'(prog_len),       64'd0);
    chk("midrst_load_ready", 64'(load_ready),     64'd0);
    chk("midrst_is_write",   64'(store_is_write), 64'd0);
    load_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Overflow: MAX_LINES+2 beats with no last
    do_load(ML + 2, 1'b0, -1);
    tick();
    chk("ovf_flag",     64'(overflow), 64'd1);
    chk("ovf_prog_len", 64'(prog_len), 64'(ML));
    chk("ovf_state",    64'(state),    64'd0);
    chk("ovf_sb_empty", 64'(exp_q.size()), 64'd0);

    // Table-driven load/run programs
    foreach (tbl[k]) begin
      do_load(tbl[k].len, tbl[k].last, tbl[k].halt);
      tick();
      chk({tbl[k].nm, "_prog_len"}, 64'(prog_len), 64'(tbl[k].eprog));
      chk({tbl[k].nm, "_overflow"}, 64'(overflow), 64'd0);
      chk({tbl[k].nm, "_idle"},     64'(state),    64'd0);
      do_run(tbl[k].nm, tbl[k].eexec, tbl[k].eidx, tbl[k].sline, tbl[k].sn);
    end

    // load_start and run_start together -> LOAD; abort keeps prog_len
    load_start = 1'b1;
    run_start  = 1'b1;
    tick();
    load_start = 1'b0;
    run_start  = 1'b0;
    chk("both_start_load", 64'(state), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_load_state",    64'(state),    64'd0);
    chk("abort_load_prog_len", 64'(prog_len), 64'(ML));

    // Abort during RUN
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    tick();
    chk("abort_run_in_run", 64'(state), 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_state", 64'(state), 64'd0);

`ifdef BREAKPOINT_EN
    begin
      int cyc;
      do_load(4, 1'b1, -1);
      tick();
      bp_en = 1'b1;
      bp_line = 32'd2;
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      cyc = 0;
      while (state != 3'd4 && cyc < 50) begin tick(); cyc++; end
      chk("bp_pause_state", 64'(state), 64'd4);
      chk("bp_pause_index", 64'(code_index), 64'd2);
      tick(); tick();
      chk("bp_hold_index", 64'(code_index), 64'd2);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      cyc = 0;
      while (state != 3'd3 && cyc < 50) begin tick(); cyc++; end
      chk("bp_done_state", 64'(state), 64'd3);
      chk("bp_exec_count", 64'(exec_count), 64'd4);
      bp_en = 1'b0;
    end
`endif

    tick();
    chk("sb_final_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
